// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the ALU operand sequencer.
package alu_seq_pkg;

    localparam int unsigned OPW       = 8;
    localparam int unsigned RESW      = 32;
    localparam int unsigned DEF_DEPTH = 4;
    localparam int unsigned DEF_HOLD  = 4;

    typedef enum logic [1:0] {
        SEQ_IDLE,
        SEQ_RUN,
        SEQ_PRESENT
    } seq_state_t;

    typedef struct packed {
        logic [OPW-1:0] a;
        logic [OPW-1:0] b;
    } op_pair_t;

endpackage

// File: rtl/alu_operand_sequencer_if.sv
// Operand stream, ALU drive/return and result stream of the sequencer.
interface alu_operand_sequencer_if;
    import alu_seq_pkg::*;

    logic            in_valid;
    logic            in_ready;
    logic [OPW-1:0]  in_a;
    logic [OPW-1:0]  in_b;
    logic [OPW-1:0]  alu_ain;
    logic [OPW-1:0]  alu_bin;
    logic            alu_s;
    logic [RESW-1:0] alu_out;
    logic            res_valid;
    logic            res_ready;
    logic [OPW-1:0]  res_a;
    logic [OPW-1:0]  res_b;
    logic [RESW-1:0] res_data;

    modport slave (
        input  in_valid, in_a, in_b, alu_out, res_ready,
        output in_ready, alu_ain, alu_bin, alu_s, res_valid, res_a, res_b, res_data
    );

    modport master (
        output in_valid, in_a, in_b, alu_out, res_ready,
        input  in_ready, alu_ain, alu_bin, alu_s, res_valid, res_a, res_b, res_data
    );

endinterface

// File: rtl/alu_operand_sequencer_fifo.sv
// Synchronous operand-pair FIFO; push is ignored when full, pop when empty.
module alu_seq_fifo
    import alu_seq_pkg::*;
#(
    parameter int unsigned DEPTH = DEF_DEPTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  op_pair_t                 wdata,
    output op_pair_t                 rdata,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    op_pair_t        mem [DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic            do_push;
    logic            do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    // Storage carries no reset; contents are only read behind a valid count.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/alu_operand_sequencer.sv
// Feeds queued operand pairs to the ALU, runs it for HOLD cycles and
// presents the captured result with its operands on a valid/ready stream.
module alu_operand_sequencer
    import alu_seq_pkg::*;
#(
    parameter int unsigned DEPTH = DEF_DEPTH,
    parameter int unsigned HOLD  = DEF_HOLD
) (
    input  logic                    clk,
    input  logic                    rst,
    alu_operand_sequencer_if.slave  bus,
    output logic                    busy,
    output logic [$clog2(DEPTH):0]  count
);

    localparam int unsigned HW = (HOLD > 1) ? $clog2(HOLD) : 1;

    seq_state_t      state;
    seq_state_t      state_nxt;
    logic [HW-1:0]   hold_cnt;
    op_pair_t        head;
    op_pair_t        wr_pair;
    logic            fifo_full;
    logic            fifo_empty;
    logic            pop;
    logic            run;
    logic            capture;

    logic [OPW-1:0]  ain_q;
    logic [OPW-1:0]  bin_q;
    logic            res_valid_q;
    logic [OPW-1:0]  res_a_q;
    logic [OPW-1:0]  res_b_q;
    logic [RESW-1:0] res_data_q;

    assign wr_pair.a = bus.in_a;
    assign wr_pair.b = bus.in_b;

    alu_seq_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (bus.in_valid),
        .pop   (pop),
        .wdata (wr_pair),
        .rdata (head),
        .count (count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= SEQ_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            SEQ_IDLE:    if (!fifo_empty) state_nxt = SEQ_RUN;
            SEQ_RUN:     if (hold_cnt == '0) state_nxt = SEQ_PRESENT;
            SEQ_PRESENT: if (bus.res_ready) state_nxt = fifo_empty ? SEQ_IDLE : SEQ_RUN;
            default:     state_nxt = SEQ_IDLE;
        endcase
    end

    // alu_s decodes the state register directly so reset drops it at once.
    always_comb begin
        pop     = 1'b0;
        run     = 1'b0;
        capture = 1'b0;
        case (state)
            SEQ_IDLE:    pop = !fifo_empty;
            SEQ_RUN: begin
                run     = 1'b1;
                capture = (hold_cnt == '0);
            end
            SEQ_PRESENT: pop = bus.res_ready && !fifo_empty;
            default:     ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ain_q       <= '0;
            bin_q       <= '0;
            hold_cnt    <= '0;
            res_valid_q <= 1'b0;
            res_a_q     <= '0;
            res_b_q     <= '0;
            res_data_q  <= '0;
        end else begin
            if (pop) begin
                ain_q    <= head.a;
                bin_q    <= head.b;
                hold_cnt <= HW'(HOLD - 1);
            end else if (run && hold_cnt != '0) begin
                hold_cnt <= hold_cnt - HW'(1);
            end
            if (capture) begin
                res_valid_q <= 1'b1;
                res_data_q  <= bus.alu_out;
                res_a_q     <= ain_q;
                res_b_q     <= bin_q;
            end else if (state == SEQ_PRESENT && bus.res_ready) begin
                res_valid_q <= 1'b0;
            end
        end
    end

    assign bus.alu_ain   = ain_q;
    assign bus.alu_bin   = bin_q;
    assign bus.alu_s     = run;
    assign bus.in_ready  = !fifo_full;
    assign bus.res_valid = res_valid_q;
    assign bus.res_a     = res_a_q;
    assign bus.res_b     = res_b_q;
    assign bus.res_data  = res_data_q;
    assign busy          = (state != SEQ_IDLE) || !fifo_empty;

endmodule

// File: tb/tb_alu_operand_sequencer.sv
// Directed and random checks of alu_operand_sequencer against a queue-based
// reference: every accepted pair must come back once, in order, as a*b.
module tb_alu_operand_sequencer;
    import alu_seq_pkg::*;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned HOLD  = 4;
    localparam int unsigned CW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          busy;
    logic [CW-1:0] count;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    int s_run       = 0;
    op_pair_t model_q [$];
    int       hs_cyc  [$];

    alu_operand_sequencer_if ifc ();

    alu_operand_sequencer #(.DEPTH(DEPTH), .HOLD(HOLD)) dut (
        .clk   (clk),
        .rst   (rst),
        .bus   (ifc.slave),
        .busy  (busy),
        .count (count)
    );

    always #5 clk = ~clk;

    // Behavioural ALU: settled product of the presented operands.
    assign ifc.alu_out = 32'(ifc.alu_ain) * 32'(ifc.alu_bin);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One clock: score the handshakes seen before the edge, then check holds.
    task automatic tick();
        logic          acc;
        logic          hs;
        logic          held;
        logic [31:0]   prev_data;
        logic [7:0]    prev_a;
        logic [7:0]    prev_b;
        op_pair_t      p;
        acc       = ifc.in_valid && ifc.in_ready;
        hs        = ifc.res_valid && ifc.res_ready;
        held      = ifc.res_valid && !ifc.res_ready;
        prev_data = ifc.res_data;
        prev_a    = ifc.res_a;
        prev_b    = ifc.res_b;
        if (hs) begin
            if (model_q.size() == 0) begin
                chk("unexpected_result", 32'(1), 32'(0));
            end else begin
                p = model_q.pop_front();
                chk("res_a", 32'(ifc.res_a), 32'(p.a));
                chk("res_b", 32'(ifc.res_b), 32'(p.b));
                chk("res_data", ifc.res_data, 32'(p.a) * 32'(p.b));
                hs_cyc.push_back(cyc);
            end
        end
        if (acc) begin
            p.a = ifc.in_a;
            p.b = ifc.in_b;
            model_q.push_back(p);
        end
        @(posedge clk);
        #1;
        cyc++;
        if (held) begin
            chk("res_valid_held", 32'(ifc.res_valid), 32'(1));
            chk("res_data_frozen", ifc.res_data, prev_data);
            chk("res_ab_frozen", {16'h0, ifc.res_a, ifc.res_b}, {16'h0, prev_a, prev_b});
        end
        if (ifc.alu_s) begin
            s_run++;
        end else if (s_run != 0) begin
            chk("alu_s_high_cycles", 32'(s_run), 32'(HOLD));
            s_run = 0;
        end
    endtask

    task automatic push(input logic [7:0] a, input logic [7:0] b);
        ifc.in_valid = 1'b1;
        ifc.in_a     = a;
        ifc.in_b     = b;
        tick();
        ifc.in_valid = 1'b0;
    endtask

    task automatic drain(input int bound);
        int n = 0;
        while (model_q.size() != 0 && n < bound) begin
            tick();
            n++;
        end
        chk("drain_empty", 32'(model_q.size()), 32'(0));
    endtask

    task automatic wait_valid(input int bound);
        int n = 0;
        while (!ifc.res_valid && n < bound) begin
            tick();
            n++;
        end
        chk("res_valid_timeout", 32'(ifc.res_valid), 32'(1));
    endtask

    initial begin
        int lat;
        rst           = 1'b1;
        ifc.in_valid  = 1'b0;
        ifc.in_a      = '0;
        ifc.in_b      = '0;
        ifc.res_ready = 1'b0;

        // Reset values.
        #7;
        chk("rst_in_ready", 32'(ifc.in_ready), 32'(1));
        chk("rst_busy", 32'(busy), 32'(0));
        chk("rst_count", 32'(count), 32'(0));
        chk("rst_alu_s", 32'(ifc.alu_s), 32'(0));
        chk("rst_res_valid", 32'(ifc.res_valid), 32'(0));
        chk("rst_res_data", ifc.res_data, 32'(0));
        chk("rst_alu_ain", {16'h0, ifc.alu_ain, ifc.alu_bin}, 32'(0));
        chk("rst_res_ab", {16'h0, ifc.res_a, ifc.res_b}, 32'(0));
        #5;
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Single op: latency HOLD+1 from accept.
        push(8'd10, 8'd3);
        lat = 0;
        do begin
            tick();
            lat++;
        end while (!ifc.res_valid && lat < 20);
        chk("single_latency", 32'(lat), 32'(HOLD + 1));
        chk("single_res_data", ifc.res_data, 32'd30);
        chk("single_res_a", 32'(ifc.res_a), 32'd10);
        chk("single_res_b", 32'(ifc.res_b), 32'd3);
        ifc.res_ready = 1'b1;
        tick();

        // Burst with res_ready high: one result every HOLD+1 cycles.
        hs_cyc.delete();
        push(8'd10, 8'd3);
        push(8'd8, 8'd2);
        push(8'd15, 8'd5);
        drain(60);
        chk("burst_results", 32'(hs_cyc.size()), 32'(3));
        chk("burst_spacing_1", 32'(hs_cyc[1] - hs_cyc[0]), 32'(HOLD + 1));
        chk("burst_spacing_2", 32'(hs_cyc[2] - hs_cyc[1]), 32'(HOLD + 1));

        // Backpressure: one in flight plus DEPTH queued fills the FIFO.
        ifc.res_ready = 1'b0;
        push(8'd10, 8'd3);
        push(8'd1, 8'd2);
        push(8'd3, 8'd4);
        push(8'd5, 8'd6);
        push(8'd7, 8'd8);
        chk("bp_count_full", 32'(count), 32'(DEPTH));
        chk("bp_in_ready", 32'(ifc.in_ready), 32'(0));
        ifc.in_valid = 1'b1;
        ifc.in_a     = 8'd9;
        ifc.in_b     = 8'd9;
        repeat (8) tick();
        chk("bp_frozen_data", ifc.res_data, 32'd30);
        chk("bp_count_hold", 32'(count), 32'(DEPTH));
        ifc.in_valid  = 1'b0;
        ifc.res_ready = 1'b1;
        drain(80);
        repeat (10) tick();
        chk("bp_idle_after", 32'(ifc.res_valid), 32'(0));

        // Simultaneous push and pop at count=2.
        ifc.res_ready = 1'b0;
        push(8'd1, 8'd1);
        push(8'd2, 8'd2);
        push(8'd3, 8'd3);
        wait_valid(20);
        chk("pp_count_before", 32'(count), 32'(2));
        ifc.res_ready = 1'b1;
        push(8'd4, 8'd4);
        chk("pp_count_after", 32'(count), 32'(2));

        // Random traffic across many pointer wraps.
        for (int i = 0; i < 80; i++) begin
            ifc.in_valid  = 1'($urandom_range(0, 1));
            ifc.in_a      = 8'($urandom);
            ifc.in_b      = 8'($urandom);
            ifc.res_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        ifc.in_valid  = 1'b0;
        ifc.res_ready = 1'b1;
        drain(200);
        repeat (6) tick();

        // Reset mid-RUN with two entries queued.
        push(8'd1, 8'd5);
        push(8'd2, 8'd6);
        push(8'd3, 8'd7);
        chk("mr_count_queued", 32'(count), 32'(2));
        chk("mr_alu_s_run", 32'(ifc.alu_s), 32'(1));
        #2;
        rst = 1'b1;
        #1;
        chk("mr_alu_s", 32'(ifc.alu_s), 32'(0));
        chk("mr_res_valid", 32'(ifc.res_valid), 32'(0));
        chk("mr_count", 32'(count), 32'(0));
        chk("mr_busy", 32'(busy), 32'(0));
        model_q.delete();
        s_run = 0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        hs_cyc.delete();
        push(8'd7, 8'd7);
        drain(40);
        repeat (15) tick();
        chk("mr_single_result", 32'(hs_cyc.size()), 32'(1));
        chk("mr_last_data", ifc.res_data, 32'd49);

        // Idle: nothing moves without pushes.
        for (int i = 0; i < 30; i++) begin
            tick();
            if (i % 10 == 9) begin
                chk("idle_busy", 32'(busy), 32'(0));
                chk("idle_alu_s", 32'(ifc.alu_s), 32'(0));
                chk("idle_res_valid", 32'(ifc.res_valid), 32'(0));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/alu_operand_sequencer.md
# alu_operand_sequencer

Upstream feeder for the 8-bit FSM ALU. Buffers operand pairs arriving on a valid/ready stream in a small FIFO and presents one pair at a time on the ALU's `ain`/`bin` inputs. Drives the ALU enable `s` for a fixed run window, then captures the 32-bit ALU result. Returns the result together with its operands on a valid/ready result stream.

## Interface
- `DEPTH`, 4: operand FIFO entries; power of two, ≥2.
- `HOLD`, 4: cycles `alu_s` stays high per operation; ≥1.
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  operand pair offered.
- `in_ready`  out  1  FIFO can accept; equals `count < DEPTH`.
- `in_a`, `in_b`  in  8 each  operands.
- `alu_ain`, `alu_bin`  out  8 each  to ALU `ain`/`bin`.
- `alu_s`  out  1  to ALU `s` (enable).
- `alu_out`  in  32  from ALU `out`.
- `res_valid`  out  1  result available.
- `res_ready`  in  1  consumer accepts result.
- `res_a`, `res_b`  out  8 each  operands that produced `res_data`.
- `res_data`  out  32  captured ALU result.
- `busy`  out  1  state ≠ IDLE or `count` ≠ 0.
- `count`  out  $clog2(DEPTH)+1  FIFO occupancy.

## Operation
- Push: `in_valid && in_ready` at an edge writes `{in_a,in_b}` to the FIFO tail. Full FIFO gives `in_ready=0`, with no pass-through even if a pop occurs in the same cycle.
- FSM states: IDLE, RUN, PRESENT.
- IDLE:
  - `alu_s=0`.
  - If `count≠0`, pop the head into the operand regs (`alu_ain`/`alu_bin`), load `hold_cnt=HOLD-1`, go to RUN.
- RUN:
  - `alu_s=1`; operand regs are held stable.
  - If `hold_cnt≠0`, decrement.
  - If `hold_cnt=0`, register `alu_out` into `res_data`, copy the operands to `res_a`/`res_b`, set `res_valid=1`, go to PRESENT.
- PRESENT:
  - `alu_s=0`; `res_*` are held stable while `res_valid && !res_ready`.
  - On `res_ready`: clear `res_valid`. If `count≠0`, pop the next pair and go to RUN (same load as IDLE). Otherwise go to IDLE.
- Consequence: `alu_s` is low for at least one cycle between consecutive operations, so the ALU FSM restarts for each pair.
- Simultaneous push and pop in one cycle: `count` is unchanged, and both take effect.
- Pointers are `$clog2(DEPTH)` bits and wrap naturally. `count` saturates logically by the `in_ready` gating; it never exceeds `DEPTH` and never underflows, because a pop only occurs when `count≠0`.
- Reset values: state=IDLE, `count=0`, pointers=0, `alu_ain=alu_bin=0`, `alu_s=0`, `res_valid=0`, `res_a=res_b=0`, `res_data=0`, `in_ready=1`, `busy=0`.
- Reset asserted mid-operation: everything returns to the reset values immediately. The in-flight operation and all FIFO contents are discarded, and `alu_s` drops asynchronously.

## Timing
- Accept edge E0 into an empty FIFO with state IDLE:
  - E1: pop; state RUN; `alu_s` high from E1.
  - E1+HOLD: capture; `res_valid` high.
  - Latency from accept to `res_valid` is HOLD+1 cycles.
- `alu_s` is high for exactly HOLD cycles per operation.
- `alu_out` is sampled at the last RUN edge; the ALU result must be settled by then.
- Back-to-back operations with `res_ready` tied high give throughput of one result per HOLD+1 cycles.
- `in_ready` and `res_valid` are registered-state functions; there is no combinational path from `res_ready` to `in_ready`.

## Structure
- Package `alu_seq_pkg`: state enum (`SEQ_IDLE`, `SEQ_RUN`, `SEQ_PRESENT`), default `DEPTH`/`HOLD` constants, operand width 8, result width 32.
- Sub-module `alu_seq_fifo`: synchronous FIFO (DEPTH×16) with push, pop, `count`, full and empty. The sequencer FSM stays in the top module.

## Test plan
The bench ALU model drives `alu_out = alu_ain*alu_bin` combinationally; HOLD=4, DEPTH=4.
- Reset then single op: hold `rst` high 12 ns, push (10,3) → `alu_s` high 4 cycles; `res_valid` 5 cycles after accept with `res_data=30`, `res_a=10`, `res_b=3`.
- Burst of (10,3), (8,2), (15,5) with `res_ready=1`:
  - results arrive in order: 30, 16, 75;
  - each result is spaced 5 cycles apart;
  - `alu_s` has a 1-cycle low gap between operations.
- Backpressure: `res_ready=0`, push 5 pairs →
  - `in_ready` drops after 4 are queued beyond the one in flight;
  - `res_*` stay frozen at 30 until `res_ready` rises;
  - no result is lost or duplicated.
- Simultaneous push and pop at `count=2` → `count` stays 2; FIFO order is preserved across pointer wrap after 6+ operations.
- Reset mid-RUN with 2 queued entries: `alu_s`, `res_valid` and `count` go to 0 immediately. The next push of (7,7) yields 49 only, with no stale results.
- Idle check: with no pushes, `busy=0`, `alu_s=0` and `res_valid=0` hold indefinitely.
